// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the multi-cycle MIPS control path.
//   - opcode constants (IR[31:26])
//   - ALUOp, ALUSrcB and PCSource select encodings
//   - 4-bit FSM state encoding (also driven out on state_dbg)
//   - ctrl_word_t: the full Moore control word produced by mips_ctrl_decode
package mips_pkg;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // ALUOp (ALU control encoding unchanged from the single-cycle design)
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand select
    localparam logic [1:0] ALUB_REG    = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMMSH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // FSM state encoding; values 13..15 are unused
    typedef logic [3:0] state_t;
    localparam state_t S_RESET  = 4'd0;
    localparam state_t S_FETCH  = 4'd1;
    localparam state_t S_DECODE = 4'd2;
    localparam state_t S_MEMADR = 4'd3;
    localparam state_t S_MEMRD  = 4'd4;
    localparam state_t S_MEMWB  = 4'd5;
    localparam state_t S_MEMWR  = 4'd6;
    localparam state_t S_EXEC   = 4'd7;
    localparam state_t S_RTWB   = 4'd8;
    localparam state_t S_BRANCH = 4'd9;
    localparam state_t S_JUMP   = 4'd10;
    localparam state_t S_ADDIEX = 4'd11;
    localparam state_t S_ADDIWB = 4'd12;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_word_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// mips_ctrl_decode: combinational state -> control-word decoder.
// Ports:
//   state     in  4   registered FSM state
//   mem_ready in  1   memory completion; only used to qualify IRWrite/PCWrite in FETCH
//   ctrl      out     control word (ctrl_word_t); all fields 0 unless the state sets them
module mips_ctrl_decode
    import mips_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    output ctrl_word_t ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = ALUB_FOUR;
                // IR and PC advance only in the cycle the fetch completes
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: ctrl.alu_src_b = ALUB_IMMSH2;
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.ior_d    = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.ior_d     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RTWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
            end
            S_ADDIWB: ctrl.reg_write = 1'b1;
            default:  ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: main control FSM for the multi-cycle MIPS datapath.
// Holds the state register, next-state logic and the retired-instruction
// counter; the control word itself comes from mips_ctrl_decode.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   opcode[5:0]         IR[31:26], meaningful from DECODE onward
//   mem_ready           memory handshake (see below)
//   PCWrite .. PCSource datapath controls (Moore, FETCH qualified by mem_ready)
//   illegal_op          high for the DECODE cycle of an undecodable opcode
//   state_dbg[3:0]      current state encoding
//   retired[CNT_W-1:0]  completed-instruction count, wraps
//
// Memory handshake: in FETCH, MEMRD and MEMWR the request (MemRead/MemWrite)
// acts as "valid" and is held high and stable until a cycle in which
// mem_ready=1; that cycle completes the access and the FSM moves on at the
// next edge. mem_ready is ignored in every other state.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int ADDI_EN = 1,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             illegal_op,
    output logic [3:0]       state_dbg,
    output logic [CNT_W-1:0] retired
);

    state_t     state, state_nxt;
    ctrl_word_t ctrl;
    logic       op_legal;
    logic       retire;

    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: op_legal = 1'b1;
            OP_ADDI:                              op_legal = (ADDI_EN != 0);
            default:                              op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_RESET:  state_nxt = S_FETCH;
            S_FETCH:  state_nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                state_nxt = S_FETCH;
                case (opcode)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_EXEC;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
                    OP_ADDI:      state_nxt = (ADDI_EN != 0) ? S_ADDIEX : S_FETCH;
                    default:      state_nxt = S_FETCH;
                endcase
            end
            // Opcode is stable after DECODE; anything but lw/sw here is
            // treated defensively as a return to FETCH.
            S_MEMADR: begin
                if (opcode == OP_LW)      state_nxt = S_MEMRD;
                else if (opcode == OP_SW) state_nxt = S_MEMWR;
                else                      state_nxt = S_FETCH;
            end
            S_MEMRD:  state_nxt = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_nxt = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_nxt = S_RTWB;
            S_ADDIEX: state_nxt = S_ADDIWB;
            default:  state_nxt = S_FETCH; // MEMWB, RTWB, BRANCH, JUMP, ADDIWB, 13..15
        endcase
    end

    // An instruction retires on the edge leaving its final state.
    always_comb begin
        case (state)
            S_MEMWB, S_RTWB, S_BRANCH, S_JUMP, S_ADDIWB: retire = 1'b1;
            S_MEMWR:                                     retire = mem_ready;
            default:                                     retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_RESET;
            retired <= '0;
        end else begin
            state <= state_nxt;
            if (retire) retired <= retired + CNT_W'(1);
        end
    end

    mips_ctrl_decode u_decode (
        .state     (state),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.ior_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign illegal_op  = (state == S_DECODE) && !op_legal;
    assign state_dbg   = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl. Two instances: the main one (addi enabled,
// 4-bit counter for wrap coverage) and a second one with addi disabled.
module tb_mips_multicycle_ctrl;

    localparam int CNT_W = 4;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RTY  = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] BAD  = 6'b111111;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT ----------------
    logic [5:0]       opcode = '0;
    logic             mem_ready = 1'b0;
    logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic             MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
    logic [1:0]       ALUSrcB, ALUOp, PCSource;
    logic [3:0]       state_dbg;
    logic [CNT_W-1:0] retired;

    mips_multicycle_ctrl #(.ADDI_EN(1), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .illegal_op(illegal_op),
        .state_dbg(state_dbg), .retired(retired)
    );

    // ---------------- addi-disabled DUT ----------------
    logic [5:0]  op_b = '0;
    logic        rdy_b = 1'b0;
    logic        pcw_b, pcwc_b, iord_b, mr_b, mw_b, irw_b, m2r_b, rd_b, rw_b, asa_b, ill_b;
    logic [1:0]  asb_b, aop_b, pcs_b;
    logic [3:0]  state_b;
    logic [7:0]  retired_b;

    mips_multicycle_ctrl #(.ADDI_EN(0), .CNT_W(8)) dut_na (
        .clk(clk), .rst_n(rst_n), .opcode(op_b), .mem_ready(rdy_b),
        .PCWrite(pcw_b), .PCWriteCond(pcwc_b), .IorD(iord_b),
        .MemRead(mr_b), .MemWrite(mw_b), .IRWrite(irw_b),
        .MemtoReg(m2r_b), .RegDst(rd_b), .RegWrite(rw_b),
        .ALUSrcA(asa_b), .ALUSrcB(asb_b), .ALUOp(aop_b),
        .PCSource(pcs_b), .illegal_op(ill_b),
        .state_dbg(state_b), .retired(retired_b)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    int exp_retired = 0;
    logic [3:0] exp_q[$];   // expected state per cycle
    logic       rdy_q[$];   // mem_ready to drive in that cycle

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Observed control word, packed in a fixed bench order.
    function automatic logic [16:0] obs_word();
        return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op};
    endfunction

    // Expected outputs per state, transcribed from the state/output table.
    function automatic logic [16:0] exp_word(input int st, input logic rdy, input logic ill);
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa;
        logic [1:0] asb, aop, pcs;
        {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa} = '0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (st)
            1:  begin mr = 1'b1; asb = 2'b01; irw = rdy; pcw = rdy; end
            2:  asb = 2'b11;
            3:  begin asa = 1'b1; asb = 2'b10; end
            4:  begin mr = 1'b1; iord = 1'b1; end
            5:  begin rw = 1'b1; m2r = 1'b1; end
            6:  begin mw = 1'b1; iord = 1'b1; end
            7:  begin asa = 1'b1; aop = 2'b10; end
            8:  begin rd = 1'b1; rw = 1'b1; end
            9:  begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
            10: begin pcw = 1'b1; pcs = 2'b10; end
            11: begin asa = 1'b1; asb = 2'b10; end
            12: rw = 1'b1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs, ill};
    endfunction

    // ---------------- driver ----------------
    // Enter at posedge+1; drive, check at negedge, return at next posedge+1.
    task automatic step(input logic [3:0] st, input logic rdy, input logic [5:0] op, input logic ill);
        opcode    = (st == 4'd1) ? 6'($urandom) : op;  // opcode is don't-care in FETCH
        mem_ready = rdy;
        @(negedge clk);
        check_eq("state", 32'(state_dbg), 32'(st));
        check_eq("ctrl", 32'(obs_word()), 32'(exp_word(int'(st), rdy, ill)));
        check_eq("retired", 32'(retired), 32'(exp_retired % (1 << CNT_W)));
        @(posedge clk);
        #1;
    endtask

    // Build the cycle-by-cycle path of one instruction from its opcode and
    // wait counts, then drive it. mem_ready is random where it is ignored.
    task automatic run_instr(input logic [5:0] op, input int fetch_wait, input int mem_wait);
        logic legal;
        legal = (op == LW) || (op == SW) || (op == RTY) || (op == BEQ) ||
                (op == JMP) || (op == ADDI);
        exp_q.delete(); rdy_q.delete();
        repeat (fetch_wait) begin exp_q.push_back(4'd1); rdy_q.push_back(1'b0); end
        exp_q.push_back(4'd1); rdy_q.push_back(1'b1);
        exp_q.push_back(4'd2); rdy_q.push_back(1'($urandom));
        case (op)
            LW: begin
                exp_q.push_back(4'd3); rdy_q.push_back(1'($urandom));
                repeat (mem_wait) begin exp_q.push_back(4'd4); rdy_q.push_back(1'b0); end
                exp_q.push_back(4'd4); rdy_q.push_back(1'b1);
                exp_q.push_back(4'd5); rdy_q.push_back(1'($urandom));
            end
            SW: begin
                exp_q.push_back(4'd3); rdy_q.push_back(1'($urandom));
                repeat (mem_wait) begin exp_q.push_back(4'd6); rdy_q.push_back(1'b0); end
                exp_q.push_back(4'd6); rdy_q.push_back(1'b1);
            end
            RTY: begin
                exp_q.push_back(4'd7); rdy_q.push_back(1'($urandom));
                exp_q.push_back(4'd8); rdy_q.push_back(1'($urandom));
            end
            BEQ: begin exp_q.push_back(4'd9);  rdy_q.push_back(1'($urandom)); end
            JMP: begin exp_q.push_back(4'd10); rdy_q.push_back(1'($urandom)); end
            ADDI: begin
                exp_q.push_back(4'd11); rdy_q.push_back(1'($urandom));
                exp_q.push_back(4'd12); rdy_q.push_back(1'($urandom));
            end
            default: ;
        endcase
        while (exp_q.size() > 0) begin
            logic [3:0] st;
            logic       r;
            st = exp_q.pop_front();
            r  = rdy_q.pop_front();
            step(st, r, op, (st == 4'd2) && !legal);
        end
        if (legal) exp_retired++;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [5:0] op_tab [0:7];
        op_tab[0] = LW;  op_tab[1] = SW;  op_tab[2] = RTY; op_tab[3] = BEQ;
        op_tab[4] = JMP; op_tab[5] = ADDI; op_tab[6] = BAD; op_tab[7] = 6'b001001;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_state", 32'(state_dbg), 32'd0);
        check_eq("rst_ctrl", 32'(obs_word()), 32'd0);
        check_eq("rst_retired", 32'(retired), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rel_state0", 32'(state_dbg), 32'd0);
        @(posedge clk); #1;

        // addi illegal when disabled: drive the second instance, main one
        // stalls in FETCH with mem_ready low.
        rdy_b = 1'b1; op_b = ADDI;
        @(negedge clk);
        check_eq("na_fetch", 32'(state_b), 32'd1);
        check_eq("na_irwrite", 32'(irw_b), 32'd1);
        @(posedge clk); #1;
        rdy_b = 1'b0;
        @(negedge clk);
        check_eq("na_decode", 32'(state_b), 32'd2);
        check_eq("na_illegal", 32'(ill_b), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("na_back_fetch", 32'(state_b), 32'd1);
        check_eq("na_illegal_off", 32'(ill_b), 32'd0);
        check_eq("na_retired", 32'(retired_b), 32'd0);
        @(posedge clk); #1;

        // Directed programme: lw, sw with 3 waits, R, beq, j, illegal, addi
        run_instr(LW, 0, 0);
        run_instr(SW, 0, 3);
        run_instr(RTY, 0, 0);
        run_instr(BEQ, 0, 0);
        run_instr(JMP, 0, 0);
        run_instr(BAD, 0, 0);
        run_instr(ADDI, 1, 0);

        // Reset in the middle of a stalled store
        step(4'd1, 1'b1, SW, 1'b0);
        step(4'd2, 1'b0, SW, 1'b0);
        step(4'd3, 1'b0, SW, 1'b0);
        opcode = SW; mem_ready = 1'b0;
        @(negedge clk);
        check_eq("mw_before_rst", 32'(MemWrite), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mw_async_drop", 32'(MemWrite), 32'd0);
        check_eq("state_async_rst", 32'(state_dbg), 32'd0);
        check_eq("retired_async_rst", 32'(retired), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_retired = 0;
        @(negedge clk);
        check_eq("after_rel_state", 32'(state_dbg), 32'd0);
        check_eq("after_rel_retired", 32'(retired), 32'd0);
        @(posedge clk); #1;

        // Counter wrap: 17 jumps on a 4-bit counter
        repeat (17) run_instr(JMP, 0, 0);
        @(negedge clk);
        check_eq("wrap_retired", 32'(retired), 32'd1);
        @(posedge clk); #1;

        // Randomized instruction stream
        repeat (80) begin
            run_instr(op_tab[$urandom_range(0, 7)], $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Main control state machine for the multi-cycle variant of our MIPS datapath. Replaces the single-cycle combinational control unit. Sequences one shared instruction/data memory, the single ALU, the PC, the IR and the register file over 3–5 cycles per instruction. Waits on a memory-ready handshake and counts retired instructions for the debug outputs.

## Interface
- `ADDI_EN`, default 1: decode opcode 001000 (addi); when 0, addi is illegal.
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk`, in, 1: rising-edge clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `opcode`, in, 6: IR[31:26]; valid from DECODE onward.
- `mem_ready`, in, 1: memory has completed the current access this cycle.
- `PCWrite`, out, 1: unconditional PC load.
- `PCWriteCond`, out, 1: PC load if ALU zero (beq).
- `IorD`, out, 1: memory address select; 0 = PC, 1 = ALUOut.
- `MemRead`, out, 1: memory read request.
- `MemWrite`, out, 1: memory write request.
- `IRWrite`, out, 1: load IR from memory data.
- `MemtoReg`, out, 1: register write data; 1 = MDR, 0 = ALUOut.
- `RegDst`, out, 1: destination register; 1 = rd, 0 = rt.
- `RegWrite`, out, 1: register file write.
- `ALUSrcA`, out, 1: ALU A select; 0 = PC, 1 = register A.
- `ALUSrcB`, out, 2: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = imm<<2.
- `ALUOp`, out, 2: 00 add, 01 sub, 10 funct-decoded (ALU control encoding unchanged).
- `PCSource`, out, 2: 00 = ALU result, 01 = ALUOut, 10 = jump address.
- `illegal_op`, out, 1: one-cycle pulse on an undecodable opcode.
- `state_dbg`, out, 4: current state encoding.
- `retired`, out, CNT_W: count of completed instructions.

## Operation
- States and transitions:
  - RESET(0) → FETCH.
  - FETCH(1): stays in FETCH while `mem_ready` = 0; → DECODE when `mem_ready` = 1.
  - DECODE(2):
    - lw/sw → MEMADR
    - R-type(000000) → EXEC
    - beq(000100) → BRANCH
    - j(000010) → JUMP
    - addi → ADDIEX
    - anything else → FETCH with `illegal_op` = 1
  - MEMADR(3): lw(100011) → MEMRD; sw(101011) → MEMWR.
  - MEMRD(4): holds until `mem_ready` = 1, then → MEMWB(5).
  - MEMWR(6): holds until `mem_ready` = 1, then → FETCH.
  - MEMWB → FETCH. EXEC(7) → RTWB(8) → FETCH. ADDIEX(11) → ADDIWB(12) → FETCH.
  - BRANCH(9) → FETCH. JUMP(10) → FETCH.
- Outputs are Moore, decoded from the registered state only; every output not listed for a state is 0.
  - FETCH: `MemRead`, `ALUSrcB` = 01. `IRWrite` and `PCWrite` only in the cycle with `mem_ready` = 1 (qualified by `mem_ready`, the sole Mealy term).
  - DECODE: `ALUSrcB` = 11.
  - MEMADR: `ALUSrcA`, `ALUSrcB` = 10.
  - MEMRD: `MemRead`, `IorD`.
  - MEMWR: `MemWrite`, `IorD`.
  - MEMWB: `RegWrite`, `MemtoReg`.
  - EXEC: `ALUSrcA`, `ALUOp` = 10.
  - RTWB: `RegDst`, `RegWrite`.
  - BRANCH: `ALUSrcA`, `ALUOp` = 01, `PCWriteCond`, `PCSource` = 01.
  - JUMP: `PCWrite`, `PCSource` = 10.
  - ADDIEX: `ALUSrcA`, `ALUSrcB` = 10.
  - ADDIWB: `RegWrite`.
- `retired` increments by 1 on the last-cycle exit of MEMWB, MEMWR, RTWB, BRANCH, JUMP and ADDIWB.
  - It wraps from all-ones to 0.
  - Illegal opcodes do not count.
- `state_dbg` values 13–15 are unreachable. If entered, they → FETCH with all outputs 0.

## Timing
- While `rst_n` = 0: state = RESET, `retired` = 0, every output 0, `state_dbg` = 0. This takes effect asynchronously, mid-instruction included.
  - A write in flight (MEMWR, RTWB) is abandoned, with `MemWrite`/`RegWrite` dropping immediately.
- The first rising edge with `rst_n` = 1 moves RESET → FETCH.
- Latency with zero-wait memory:
  - lw: 5 cycles.
  - sw, R-type, addi: 4 cycles.
  - beq, j: 3 cycles.
- Each memory wait cycle adds 1. `mem_ready` is sampled only in FETCH, MEMRD and MEMWR, and ignored elsewhere.
- `MemRead`/`MemWrite` stay high and stable until the cycle `mem_ready` is seen. Memory must not assume a one-cycle request.
- `illegal_op` is high for exactly the DECODE cycle.

## Structure
- Shared package `mips_pkg`:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
  - ALUOp constants
  - PCSource and ALUSrcB select constants
  - state enumeration (4-bit)
- One sub-module, `mips_ctrl_decode`: combinational state → control-word decoder. The top module holds the state register, next-state logic and the `retired` counter.

## Test plan
- Reset mid-MEMWR (assert `rst_n` = 0 while `MemWrite` = 1):
  - `MemWrite` = 0 with no clock.
  - After release: `state_dbg` = 0, then 1 on the next edge; `retired` = 0.
- lw (opcode 100011), `mem_ready` tied 1:
  - `state_dbg` sequence 1,2,3,4,5,1.
  - `IRWrite` only in cycle 1; `RegWrite` + `MemtoReg` in cycle 5.
  - `retired` 0 → 1.
- sw with `mem_ready` low for 3 cycles in MEMWR:
  - `MemWrite` high for 4 consecutive cycles, `IorD` = 1 throughout.
  - 7 cycles total; `retired` +1.
- Sequence R-type, beq, j:
  - Cycle counts 4, 3, 3.
  - BRANCH shows `ALUOp` = 01, `PCWriteCond` = 1.
  - JUMP shows `PCSource` = 10, `PCWrite` = 1.
  - `retired` = 3.
- Illegal opcode 111111, then `ADDI_EN` = 0 with opcode 001000:
  - `illegal_op` pulses once each and the FSM returns to FETCH.
  - `retired` unchanged.
- Counter wrap (`CNT_W` = 4): 17 j instructions leave `retired` = 1.
